// File: rtl/llm_req_arbiter_pkg.sv
// Shared definitions for the tag-lookup front-end arbiter.
//   llm_arb_state_e      : issue-register state (idle / offering to the pipe)
//   LLM_ARB_NUM_REQ      : default requester count
//   LLM_ARB_MAX_INFLIGHT : default number of pipeline lookup credits
package llm_req_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OFFER
  } llm_arb_state_e;

  localparam int LLM_ARB_NUM_REQ      = 4;
  localparam int LLM_ARB_MAX_INFLIGHT = 8;

endpackage

// File: rtl/llm_prio_rr_pick.sv
// Combinational priority picker with round-robin tie-break.
// The highest priority among valid requesters wins; among equal-priority
// requesters, the first index at or after ptr (wrapping) wins.
// Ports:
//   valid [NUM_REQ]         : per-requester valid
//   prio  [NUM_REQ*PRIO_W]  : packed priorities, requester i in slice i
//   ptr   [IDX_W]           : round-robin start index
//   grant [NUM_REQ]         : one-hot winner (all zero when nothing valid)
//   idx   [IDX_W]           : winner index (0 when nothing valid)
module llm_prio_rr_pick
  import llm_req_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = LLM_ARB_NUM_REQ,
  parameter int  PRIO_W  = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [NUM_REQ*PRIO_W-1:0] prio,
  input  logic [IDX_W-1:0]          ptr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [IDX_W-1:0]          idx
);

  logic [PRIO_W-1:0] max_prio;
  logic              found;

  // An all-zero max is safe: a valid requester at priority 0 still matches it.
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid[i] && (prio[i*PRIO_W +: PRIO_W] > max_prio)) begin
        max_prio = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && valid[j] && (prio[j*PRIO_W +: PRIO_W] == max_prio)) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/llm_req_arbiter.sv
// Front-end scheduler for the tag-lookup pipeline. Arbitrates NUM_REQ
// requesters onto one registered issue port (priority + round-robin), and
// bounds in-flight lookups with a credit counter.
// Optional build macro LLM_ARB_AGING_EN: per-requester age counters promote a
// requester waiting AGE_THRESH cycles to the maximum priority.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/req_ready              : per-requester handshake (ready = capture)
//   req_addr/req_prio/req_txn_id     : packed per-requester payload
//   pipe_valid/pipe_ready            : issue handshake
//   pipe_addr/prio/txn_id/src        : issued payload and winning index
//   cpl_valid                        : pipeline returns one credit
//   credit_cnt                       : free credits
//   err_credit                       : sticky credit-overflow error
module llm_req_arbiter
  import llm_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = LLM_ARB_NUM_REQ,
  parameter int ADDR_W       = 64,
  parameter int PRIO_W       = 3,
  parameter int TXN_W        = 16,
  parameter int MAX_INFLIGHT = LLM_ARB_MAX_INFLIGHT,
  parameter int AGE_THRESH   = 15
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]          req_addr,
  input  logic [NUM_REQ*PRIO_W-1:0]          req_prio,
  input  logic [NUM_REQ*TXN_W-1:0]           req_txn_id,
  output logic                               pipe_valid,
  input  logic                               pipe_ready,
  output logic [ADDR_W-1:0]                  pipe_addr,
  output logic [PRIO_W-1:0]                  pipe_prio,
  output logic [TXN_W-1:0]                   pipe_txn_id,
  output logic [$clog2(NUM_REQ)-1:0]         pipe_src,
  input  logic                               cpl_valid,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  credit_cnt,
  output logic                               err_credit
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_INFLIGHT);

  llm_arb_state_e              state, state_nxt;
  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            win_idx;
  logic [NUM_REQ-1:0]          win_grant;
  logic [NUM_REQ*PRIO_W-1:0]   eff_prio;
  logic                        cap;
  logic                        cpl_ok;
  logic [CNT_W-1:0]            credit_q;
  logic                        err_q;
  logic [ADDR_W-1:0]           addr_p1;
  logic [PRIO_W-1:0]           prio_p1;
  logic [TXN_W-1:0]            txn_p1;
  logic [IDX_W-1:0]            src_p1;

`ifdef LLM_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_THRESH+1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_THRESH);

  logic [AGE_W-1:0] age_q [NUM_REQ];

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a >= AGE_MAX) ? a : a + 1'b1;
  endfunction

  // A requester ages only while it is asking and not being captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || req_ready[i]) age_q[i] <= '0;
        else                               age_q[i] <= age_sat_inc(age_q[i]);
      end
    end
  end

  always_comb begin
    eff_prio = req_prio;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (age_q[i] == AGE_MAX) eff_prio[i*PRIO_W +: PRIO_W] = '1;
    end
  end
`else
  logic unused_age_cfg;
  assign unused_age_cfg = (AGE_THRESH != 0);
  assign eff_prio       = req_prio;
`endif

  llm_prio_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PRIO_W  (PRIO_W)
  ) u_pick (
    .valid (req_valid),
    .prio  (eff_prio),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // A new request may enter the issue register when it is empty or being
  // drained this cycle, and a credit is available.
  assign cap       = ((state == ARB_IDLE) || pipe_ready) && (credit_q != '0) && (|req_valid);
  assign req_ready = cap ? win_grant : '0;
  assign cpl_ok    = cpl_valid && (credit_q != CREDIT_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (cap) state_nxt = ARB_OFFER;
      ARB_OFFER: if (pipe_ready && !cap) state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      credit_q <= CREDIT_MAX;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap) rr_ptr <= (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + 1'b1;
      if (cap && !cpl_ok)      credit_q <= credit_q - 1'b1;
      else if (!cap && cpl_ok) credit_q <= credit_q + 1'b1;
      if (cpl_valid && (credit_q == CREDIT_MAX)) err_q <= 1'b1;
    end
  end

  // Stage p1: registered issue payload, held until accepted by the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1 <= '0;
      prio_p1 <= '0;
      txn_p1  <= '0;
      src_p1  <= '0;
    end else if (cap) begin
      addr_p1 <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      prio_p1 <= req_prio[int'(win_idx)*PRIO_W +: PRIO_W];
      txn_p1  <= req_txn_id[int'(win_idx)*TXN_W +: TXN_W];
      src_p1  <= win_idx;
    end
  end

  assign pipe_valid  = (state == ARB_OFFER);
  assign pipe_addr   = addr_p1;
  assign pipe_prio   = prio_p1;
  assign pipe_txn_id = txn_p1;
  assign pipe_src    = src_p1;
  assign credit_cnt  = credit_q;
  assign err_credit  = err_q;

endmodule

// File: tb/tb_llm_req_arbiter.sv
// Directed bench for llm_req_arbiter (default parameters: 4 requesters,
// 8 credits). Optional aging behaviour follows LLM_ARB_AGING_EN.
module tb_llm_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int PW = 3;
  localparam int TW = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*PW-1:0] req_prio;
  logic [N*TW-1:0] req_txn_id;
  logic            pipe_valid;
  logic            pipe_ready;
  logic [AW-1:0]   pipe_addr;
  logic [PW-1:0]   pipe_prio;
  logic [TW-1:0]   pipe_txn_id;
  logic [1:0]      pipe_src;
  logic            cpl_valid;
  logic [3:0]      credit_cnt;
  logic            err_credit;

  int errors = 0;
  int checks = 0;

  llm_req_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_prio    (req_prio),
    .req_txn_id  (req_txn_id),
    .pipe_valid  (pipe_valid),
    .pipe_ready  (pipe_ready),
    .pipe_addr   (pipe_addr),
    .pipe_prio   (pipe_prio),
    .pipe_txn_id (pipe_txn_id),
    .pipe_src    (pipe_src),
    .cpl_valid   (cpl_valid),
    .credit_cnt  (credit_cnt),
    .err_credit  (err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_req(input int i, input logic [2:0] p, input logic [15:0] t);
    req_prio[i*PW +: PW]   = p;
    req_txn_id[i*TW +: TW] = t;
    req_addr[i*AW +: AW]   = {48'hCAFE_0000_0000, t};
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_prio   = '0;
    req_txn_id = '0;
    pipe_ready = 1'b0;
    cpl_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_prio = '0; req_txn_id = '0;
    pipe_ready = 1'b0; cpl_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL rst_pipe_valid got=%0b want=0", pipe_valid); end
    checks++; if (credit_cnt !== 4'd8) begin errors++; $display("FAIL rst_credit got=%0d want=8", credit_cnt); end
    checks++; if (err_credit !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b want=0", err_credit); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
    checks++; if (pipe_addr !== 64'd0 || pipe_txn_id !== 16'd0 || pipe_src !== 2'd0 || pipe_prio !== 3'd0) begin
      errors++; $display("FAIL rst_payload got addr=%0h txn=%0h src=%0d prio=%0d want all 0", pipe_addr, pipe_txn_id, pipe_src, pipe_prio);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    drive_req(2, 3'd3, 16'h0012);
    req_valid  = 4'b0100;
    pipe_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    checks++; if (pipe_valid !== 1'b1 || pipe_txn_id !== 16'h0012 || pipe_src !== 2'd2) begin
      errors++; $display("FAIL single_issue got v=%0b txn=%0h src=%0d want v=1 txn=12 src=2", pipe_valid, pipe_txn_id, pipe_src);
    end
    checks++; if (pipe_prio !== 3'd3 || pipe_addr !== 64'hCAFE_0000_0000_0012) begin
      errors++; $display("FAIL single_payload got prio=%0d addr=%0h want prio=3 addr=cafe000000000012", pipe_prio, pipe_addr);
    end
    checks++; if (credit_cnt !== 4'd7) begin errors++; $display("FAIL single_credit got=%0d want=7", credit_cnt); end
    @(posedge clk); #1;
    checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b want=0", pipe_valid); end
  endtask

  task automatic test_priority();
    int exp_src[3] = '{1, 3, 0};
    do_reset();
    drive_req(0, 3'd1, 16'h0100);
    drive_req(1, 3'd6, 16'h0101);
    drive_req(3, 3'd4, 16'h0103);
    req_valid  = 4'b1011;
    pipe_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready !== (4'b0001 << exp_src[k])) begin
        errors++; $display("FAIL prio_ready[%0d] got=%b want_idx=%0d", k, req_ready, exp_src[k]);
      end
      @(posedge clk); #1;
      req_valid[exp_src[k]] = 1'b0;
      #1;
      checks++; if (pipe_valid !== 1'b1 || pipe_src !== 2'(exp_src[k])) begin
        errors++; $display("FAIL prio_src[%0d] got v=%0b src=%0d want v=1 src=%0d", k, pipe_valid, pipe_src, exp_src[k]);
      end
    end
    checks++; if (credit_cnt !== 4'd5) begin errors++; $display("FAIL prio_credit got=%0d want=5", credit_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, 3'd5, 16'(16'h0200 + i));
    req_valid  = 4'b1111;
    pipe_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got=%b want=0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (pipe_src !== 2'(k % 4) || pipe_txn_id !== 16'(16'h0200 + (k % 4))) begin
        errors++; $display("FAIL rr_src[%0d] got src=%0d txn=%0h want src=%0d", k, pipe_src, pipe_txn_id, k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_req(0, 3'd2, 16'h00A0);
    drive_req(1, 3'd2, 16'h00B1);
    req_valid  = 4'b0011;
    pipe_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (pipe_valid !== 1'b1 || pipe_txn_id !== 16'h00A0 || pipe_src !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%0b txn=%0h src=%0d want v=1 txn=a0 src=0", c, pipe_valid, pipe_txn_id, pipe_src);
      end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_noready[%0d] got=%b want=0000", c, req_ready); end
      @(posedge clk); #1;
    end
    pipe_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b want=0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (pipe_valid !== 1'b1 || pipe_src !== 2'd1 || pipe_txn_id !== 16'h00B1) begin
      errors++; $display("FAIL bp_next got v=%0b src=%0d txn=%0h want v=1 src=1 txn=b1", pipe_valid, pipe_src, pipe_txn_id);
    end
    checks++; if (credit_cnt !== 4'd6) begin errors++; $display("FAIL bp_credit got=%0d want=6", credit_cnt); end
  endtask

  task automatic test_credits();
    int n_cap = 0;
    do_reset();
    drive_req(0, 3'd3, 16'h00C0);
    req_valid  = 4'b0001;
    pipe_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready[0]) n_cap++;
      @(posedge clk); #1;
    end
    checks++; if (n_cap !== 8) begin errors++; $display("FAIL cred_caps got=%0d want=8", n_cap); end
    checks++; if (credit_cnt !== 4'd0) begin errors++; $display("FAIL cred_zero got=%0d want=0", credit_cnt); end
    checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL cred_drained got=%0b want=0", pipe_valid); end
    cpl_valid = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL cred_blocked got=%b want=0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (credit_cnt !== 4'd1) begin errors++; $display("FAIL cred_return got=%0d want=1", credit_cnt); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL cred_cap_cpl_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (credit_cnt !== 4'd1 || pipe_valid !== 1'b1) begin
      errors++; $display("FAIL cred_same_cycle got credit=%0d v=%0b want credit=1 v=1", credit_cnt, pipe_valid);
    end
    req_valid = '0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (credit_cnt !== 4'd8 || err_credit !== 1'b0) begin
      errors++; $display("FAIL cred_full got credit=%0d err=%0b want credit=8 err=0", credit_cnt, err_credit);
    end
    @(posedge clk); #1;
    checks++; if (err_credit !== 1'b1 || credit_cnt !== 4'd8) begin
      errors++; $display("FAIL cred_overflow got err=%0b credit=%0d want err=1 credit=8", err_credit, credit_cnt);
    end
    cpl_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (err_credit !== 1'b1) begin errors++; $display("FAIL cred_sticky got=%0b want=1", err_credit); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive_req(2, 3'd1, 16'h0055);
    req_valid  = 4'b0100;
    pipe_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (pipe_valid !== 1'b1 || credit_cnt !== 4'd7) begin
      errors++; $display("FAIL mid_hold got v=%0b credit=%0d want v=1 credit=7", pipe_valid, credit_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (pipe_valid !== 1'b0 || credit_cnt !== 4'd8 || pipe_txn_id !== 16'd0) begin
      errors++; $display("FAIL mid_reset got v=%0b credit=%0d txn=%0h want v=0 credit=8 txn=0", pipe_valid, credit_cnt, pipe_txn_id);
    end
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_aging();
    int got = -1;
    do_reset();
    drive_req(0, 3'd0, 16'h00E0);
    drive_req(1, 3'd7, 16'h00E1);
    req_valid  = 4'b0011;
    pipe_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cpl_valid = (credit_cnt < 4'd8);
      #1;
      if (req_ready[0] && got < 0) got = c;
      @(posedge clk); #1;
      if (got == c) begin
        checks++; if (pipe_src !== 2'd0 || pipe_prio !== 3'd0 || pipe_txn_id !== 16'h00E0) begin
          errors++; $display("FAIL age_issue got src=%0d prio=%0d txn=%0h want src=0 prio=0 txn=e0", pipe_src, pipe_prio, pipe_txn_id);
        end
      end
    end
    cpl_valid = 1'b0;
    req_valid = '0;
`ifdef LLM_ARB_AGING_EN
    checks++; if (got < 0 || got > 15) begin errors++; $display("FAIL age_capture got_cycle=%0d want 0..15", got); end
`else
    checks++; if (got != -1) begin errors++; $display("FAIL age_starve got_cycle=%0d want never (-1)", got); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_credits();
    test_reset_midflight();
    test_aging();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
